// File: rtl/cv32e40p_config_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_config_pkg
// Core-wide configuration constants consumed as parameter defaults.
//   FPU_ADDMUL_LAT : add/mul result latency in cycles (1..4)
//   FPU_OTHERS_LAT : div/sqrt/cvt/cmp result latency in cycles (1..4)
//   ZFINX          : 1 = FP results target the integer regfile (5-bit rd)
// ---------------------------------------------------------------------------
package cv32e40p_config_pkg;

    localparam int unsigned FPU_ADDMUL_LAT = 2;
    localparam int unsigned FPU_OTHERS_LAT = 2;
    localparam int unsigned ZFINX          = 1;

endpackage

// File: rtl/cv32e40p_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types for the FPU writeback sequencer.
//   fpu_lat_class_e : latency class of an FPU operation (ADDMUL / OTHERS)
//   fpu_wb_entry_t  : one in-flight result slot {valid, rd, class}; rd is
//                     always 6 bits wide, users take the low RD_W bits.
// ---------------------------------------------------------------------------
package cv32e40p_pkg;

    typedef enum logic {
        ADDMUL = 1'b0,
        OTHERS = 1'b1
    } fpu_lat_class_e;

    typedef struct packed {
        logic           valid;
        logic [5:0]     rd;
        fpu_lat_class_e lat_class;
    } fpu_wb_entry_t;

endpackage

// File: rtl/cv32e40p_fpu_wb_sequencer.sv
// ---------------------------------------------------------------------------
// cv32e40p_fpu_wb_sequencer
// Tracks in-flight FPU results in a shift line of MAX_LAT stages so that each
// accepted operation writes back exactly L cycles after issue, never two in
// the same cycle, and never out of order with an older write to the same rd.
//
// Ports
//   clk_i          : clock, all state on the rising edge
//   rst_i          : synchronous active-high reset
//   req_valid_i    : FPU operation offered for issue
//   req_class_i    : 0 = ADDMUL, 1 = OTHERS (selects the latency L)
//   req_rd_i       : destination register of the offered operation
//   req_ready_o    : issue slot free for the offered class/rd
//   flush_i        : discard every in-flight result
//   wb_valid_o     : a result writes back this cycle
//   wb_rd_o        : writeback destination
//   wb_class_o     : class of the writeback entry
//   outstanding_o  : number of valid in-flight entries
//
// Handshake: a request is accepted in a cycle where req_valid_i and
// req_ready_o are both 1. req_ready_o is a function of state, class, rd,
// flush and reset only; it never looks at req_valid_i, so the issuer may
// hold or drop valid freely.
// ---------------------------------------------------------------------------
module cv32e40p_fpu_wb_sequencer
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDMUL_LAT = cv32e40p_config_pkg::FPU_ADDMUL_LAT,
    parameter int unsigned OTHERS_LAT = cv32e40p_config_pkg::FPU_OTHERS_LAT,
    parameter int unsigned ZFINX      = cv32e40p_config_pkg::ZFINX,
    localparam int unsigned RD_W      = (ZFINX != 0) ? 5 : 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  logic            req_class_i,
    input  logic [RD_W-1:0] req_rd_i,
    output logic            req_ready_o,
    input  logic            flush_i,
    output logic            wb_valid_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic            wb_class_o,
    output logic [2:0]      outstanding_o
);

    localparam int unsigned MAX_LAT = (ADDMUL_LAT > OTHERS_LAT) ? ADDMUL_LAT : OTHERS_LAT;

    if ((ADDMUL_LAT < 1) || (ADDMUL_LAT > 4) || (OTHERS_LAT < 1) || (OTHERS_LAT > 4)) begin : g_bad_lat
        $error("cv32e40p_fpu_wb_sequencer: latencies must lie in 1..4");
    end

    // stage_q[k] holds the entry that writes back k-1 cycles from now.
    fpu_wb_entry_t stage_q [1:MAX_LAT];
    fpu_wb_entry_t stage_d [1:MAX_LAT];

    fpu_wb_entry_t req_entry;
    logic [2:0]    req_lat;
    logic          collide;
    logic          waw;
    logic          accept;
    logic [2:0]    outstanding;
    logic          unused_rd_msb;

    assign req_lat   = req_class_i ? 3'(OTHERS_LAT) : 3'(ADDMUL_LAT);
    assign req_entry = '{valid: 1'b1, rd: 6'(req_rd_i), lat_class: fpu_lat_class_e'(req_class_i)};

    // Stage 1 is left out of both checks: it retires this cycle, so it can
    // neither share the new entry's slot nor be overtaken by it.
    always_comb begin
        collide = 1'b0;
        waw     = 1'b0;
        for (int k = 2; k <= int'(MAX_LAT); k++) begin
            if (stage_q[k].valid && (k == int'(req_lat) + 1)) begin
                collide = 1'b1;
            end
            if (stage_q[k].valid && (stage_q[k].rd == 6'(req_rd_i))) begin
                waw = 1'b1;
            end
        end
    end

    assign req_ready_o = !rst_i && !flush_i && !collide && !waw;
    assign accept      = req_valid_i && req_ready_o;

    // The slot an accepted request lands in is empty by construction: its
    // upstream neighbour was checked free by the collision test.
    for (genvar k = 1; k <= int'(MAX_LAT); k++) begin : g_stage
        fpu_wb_entry_t shifted;
        if (k < int'(MAX_LAT)) begin : g_shift
            assign shifted = stage_q[k+1];
        end else begin : g_tail
            assign shifted = '0;
        end
        assign stage_d[k] = (accept && (req_lat == 3'(k))) ? req_entry : shifted;
    end

    always_ff @(posedge clk_i) begin
        for (int k = 1; k <= int'(MAX_LAT); k++) begin
            stage_q[k] <= (rst_i || flush_i) ? '0 : stage_d[k];
        end
    end

    always_comb begin
        outstanding = '0;
        for (int k = 1; k <= int'(MAX_LAT); k++) begin
            outstanding = outstanding + 3'(stage_q[k].valid);
        end
    end

    assign outstanding_o = outstanding;
    assign wb_valid_o    = stage_q[1].valid;
    assign wb_rd_o       = stage_q[1].rd[RD_W-1:0];
    assign wb_class_o    = stage_q[1].lat_class;

    // With a 5-bit rd the top bit of the stored register number is never read.
    assign unused_rd_msb = stage_q[1].rd[5];

endmodule

// File: tb/tb_cv32e40p_fpu_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_fpu_wb_sequencer
// Two instances: dut_a with default latencies (2/2), dut_b with ADDMUL=3,
// OTHERS=1. Directed steps on both, then randomized issue on dut_b checked
// against a model that keeps in-flight results as {due cycle, rd, class}.
// ---------------------------------------------------------------------------
module tb_cv32e40p_fpu_wb_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (2/2) ----------------
    logic       a_rst, a_valid, a_cls, a_flush;
    logic [4:0] a_rd;
    logic       a_ready, a_wb_valid, a_wb_cls;
    logic [4:0] a_wb_rd;
    logic [2:0] a_out;

    cv32e40p_fpu_wb_sequencer dut_a (
        .clk_i        (clk),
        .rst_i        (a_rst),
        .req_valid_i  (a_valid),
        .req_class_i  (a_cls),
        .req_rd_i     (a_rd),
        .req_ready_o  (a_ready),
        .flush_i      (a_flush),
        .wb_valid_o   (a_wb_valid),
        .wb_rd_o      (a_wb_rd),
        .wb_class_o   (a_wb_cls),
        .outstanding_o(a_out)
    );

    // ---------------- DUT B (3/1) ----------------
    logic       b_rst, b_valid, b_cls, b_flush;
    logic [4:0] b_rd;
    logic       b_ready, b_wb_valid, b_wb_cls;
    logic [4:0] b_wb_rd;
    logic [2:0] b_out;

    cv32e40p_fpu_wb_sequencer #(
        .ADDMUL_LAT(3),
        .OTHERS_LAT(1)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (b_rst),
        .req_valid_i  (b_valid),
        .req_class_i  (b_cls),
        .req_rd_i     (b_rd),
        .req_ready_o  (b_ready),
        .flush_i      (b_flush),
        .wb_valid_o   (b_wb_valid),
        .wb_rd_o      (b_wb_rd),
        .wb_class_o   (b_wb_cls),
        .outstanding_o(b_out)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] due;
        logic [4:0]  rd;
        logic        cls;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic a_set(input logic v, input logic c, input int rd, input logic fl, input logic rs);
        a_valid = v; a_cls = c; a_rd = 5'(rd); a_flush = fl; a_rst = rs;
    endtask

    task automatic b_set(input logic v, input logic c, input int rd, input logic fl, input logic rs);
        b_valid = v; b_cls = c; b_rd = 5'(rd); b_flush = fl; b_rst = rs;
    endtask

    task automatic a_wb(input string tag, input logic v, input int rd, input logic c, input int outst);
        chk({tag, "_wbv"}, a_wb_valid, v);
        if (v) begin
            chk({tag, "_wbrd"}, a_wb_rd, rd);
            chk({tag, "_wbcls"}, a_wb_cls, c);
        end
        chk({tag, "_outst"}, a_out, outst);
    endtask

    task automatic b_wb(input string tag, input logic v, input int rd, input logic c, input int outst);
        chk({tag, "_wbv"}, b_wb_valid, v);
        if (v) begin
            chk({tag, "_wbrd"}, b_wb_rd, rd);
            chk({tag, "_wbcls"}, b_wb_cls, c);
        end
        chk({tag, "_outst"}, b_out, outst);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int   cyc;
        int   lat;
        logic r_valid, r_cls, r_flush, r_rst;
        int   r_rd;
        logic exp_ready, exp_v, exp_c;
        int   exp_rd;
        exp_t keep[$];

        // Reset both instances; valid held high to show ready ignores it.
        a_set(1, 0, 0, 0, 1);
        b_set(1, 0, 0, 0, 1);
        tick();
        settle();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_a_wbv", a_wb_valid, 0);
        chk("rst_a_wbrd", a_wb_rd, 0);
        chk("rst_a_wbcls", a_wb_cls, 0);
        chk("rst_a_outst", a_out, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_b_wbv", b_wb_valid, 0);
        chk("rst_b_outst", b_out, 0);
        tick();

        // A: single ADDMUL rd=5 -> writeback in cycle 2 only
        a_set(1, 0, 5, 0, 0); b_set(0, 0, 0, 0, 0);
        settle(); chk("a1_c0_ready", a_ready, 1); tick();
        a_set(0, 0, 0, 0, 0);
        settle(); a_wb("a1_c1", 0, 0, 0, 1); tick();
        settle(); a_wb("a1_c2", 1, 5, 0, 1); tick();
        settle(); a_wb("a1_c3", 0, 0, 0, 0); tick();

        // A: back-to-back rd=1, rd=2 -> writebacks in cycles 2 and 3
        a_set(1, 0, 1, 0, 0);
        settle(); chk("a2_c0_ready", a_ready, 1); tick();
        a_set(1, 0, 2, 0, 0);
        settle(); chk("a2_c1_ready", a_ready, 1); a_wb("a2_c1", 0, 0, 0, 1); tick();
        a_set(0, 0, 0, 0, 0);
        settle(); a_wb("a2_c2", 1, 1, 0, 2); tick();
        settle(); a_wb("a2_c3", 1, 2, 0, 1); tick();
        settle(); a_wb("a2_c4", 0, 0, 0, 0); tick();

        // A: WAW on rd=9 (OTHERS); re-offer is blocked until the entry is in stage 1
        a_set(1, 1, 9, 0, 0);
        settle(); chk("a3_c0_ready", a_ready, 1); tick();
        settle(); chk("a3_c1_ready", a_ready, 0); tick();
        settle(); chk("a3_c2_ready", a_ready, 1); a_wb("a3_c2", 1, 9, 1, 1); tick();
        a_set(0, 0, 0, 0, 0);
        settle(); a_wb("a3_c3", 0, 0, 0, 1); tick();
        settle(); a_wb("a3_c4", 1, 9, 1, 1); tick();
        settle(); a_wb("a3_c5", 0, 0, 0, 0); tick();

        // A: flush with two entries in flight; flush-cycle writeback still shows
        a_set(1, 0, 3, 0, 0);
        settle(); chk("a4_c0_ready", a_ready, 1); tick();
        a_set(1, 0, 4, 0, 0);
        settle(); chk("a4_c1_ready", a_ready, 1); tick();
        a_set(1, 0, 10, 1, 0);
        settle(); chk("a4_c2_ready", a_ready, 0); a_wb("a4_c2", 1, 3, 0, 2); tick();
        a_set(0, 0, 0, 0, 0);
        settle(); a_wb("a4_c3", 0, 0, 0, 0); tick();
        settle(); a_wb("a4_c4", 0, 0, 0, 0); tick();

        // A: reset mid-flight, with a simultaneous offer
        a_set(1, 0, 11, 0, 0);
        settle(); chk("a5_c0_ready", a_ready, 1); tick();
        a_set(1, 0, 12, 0, 1);
        settle(); chk("a5_c1_ready", a_ready, 0); chk("a5_c1_outst", a_out, 1); tick();
        a_set(0, 0, 0, 0, 0);
        settle();
        chk("a5_c2_wbv", a_wb_valid, 0);
        chk("a5_c2_wbrd", a_wb_rd, 0);
        chk("a5_c2_wbcls", a_wb_cls, 0);
        chk("a5_c2_outst", a_out, 0);
        tick();
        settle(); a_wb("a5_c3", 0, 0, 0, 0); tick();
        settle(); a_wb("a5_c4", 0, 0, 0, 0); tick();

        // B: ADDMUL rd=4, then OTHERS rd=6 fits in front of it; a later OTHERS collides
        b_set(1, 0, 4, 0, 0);
        settle(); chk("b1_c0_ready", b_ready, 1); tick();
        b_set(1, 1, 6, 0, 0);
        settle(); chk("b1_c1_ready", b_ready, 1); b_wb("b1_c1", 0, 0, 0, 1); tick();
        b_set(1, 1, 8, 0, 0);
        settle(); chk("b1_c2_ready", b_ready, 0); b_wb("b1_c2", 1, 6, 1, 2); tick();
        b_set(0, 0, 0, 0, 0);
        settle(); b_wb("b1_c3", 1, 4, 0, 1); tick();
        settle(); b_wb("b1_c4", 0, 0, 0, 0); tick();

        // B: WAW on rd=7 (lat 3). The first entry writes back in cycle 3, so it
        // sits in stage 2 during cycle 2 and only reaches stage 1 in cycle 3.
        b_set(1, 0, 7, 0, 0);
        settle(); chk("b2_c0_ready", b_ready, 1); tick();
        settle(); chk("b2_c1_ready", b_ready, 0); tick();
        settle(); chk("b2_c2_ready", b_ready, 0); tick();
        settle(); chk("b2_c3_ready", b_ready, 1); b_wb("b2_c3", 1, 7, 0, 1); tick();
        b_set(0, 0, 0, 0, 0);
        settle(); b_wb("b2_c4", 0, 0, 0, 1); tick();
        settle(); b_wb("b2_c5", 0, 0, 0, 1); tick();
        settle(); b_wb("b2_c6", 1, 7, 0, 1); tick();
        settle(); b_wb("b2_c7", 0, 0, 0, 0); tick();

        // B: randomized issue against the due-cycle model
        exp_q.delete();
        cyc = 0;
        for (int n = 0; n < 600; n++) begin
            r_valid = ($urandom_range(0, 9) < 6);
            r_cls   = 1'($urandom_range(0, 1));
            r_rd    = int'($urandom_range(0, 7));
            r_flush = ($urandom_range(0, 39) == 0);
            r_rst   = ($urandom_range(0, 79) == 0);
            b_set(r_valid, r_cls, r_rd, r_flush, r_rst);

            lat       = r_cls ? 1 : 3;
            exp_ready = !r_rst && !r_flush;
            exp_v     = 1'b0;
            exp_rd    = 0;
            exp_c     = 1'b0;
            foreach (exp_q[i]) begin
                if (int'(exp_q[i].due) == cyc) begin
                    exp_v  = 1'b1;
                    exp_rd = int'(exp_q[i].rd);
                    exp_c  = exp_q[i].cls;
                end
                // Same writeback slot already taken
                if (int'(exp_q[i].due) == cyc + lat) exp_ready = 1'b0;
                // Older write to the same rd still pending after this cycle
                if ((int'(exp_q[i].due) > cyc) && (int'(exp_q[i].rd) == r_rd)) exp_ready = 1'b0;
            end

            settle();
            chk("rnd_ready", b_ready, exp_ready);
            b_wb("rnd", exp_v, exp_rd, exp_c, exp_q.size());

            if (r_rst || r_flush) begin
                exp_q.delete();
            end else begin
                keep.delete();
                foreach (exp_q[i]) if (int'(exp_q[i].due) != cyc) keep.push_back(exp_q[i]);
                exp_q = keep;
                if (r_valid && exp_ready) exp_q.push_back('{32'(cyc + lat), 5'(r_rd), r_cls});
            end
            cyc++;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
